// File: rtl/gpu.sv
// rtl/gpu.sv - shared FSM states and voxel-word field layout for the voxel feeder
package gpu;

  typedef enum logic [2:0] {
    IDLE,
    R_FETCH,
    R_LOAD,
    R_ISSUE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    FINISH
  } state_t;

  // Voxel word is {id, z, y, x}, x in the least significant coordinate slot.
  localparam int X_FIELD  = 0;
  localparam int Y_FIELD  = 1;
  localparam int Z_FIELD  = 2;
  localparam int ID_FIELD = 3;

  function automatic int field_lsb(input int field, input int coord_bits);
    return field * coord_bits;
  endfunction

endpackage

// File: rtl/voxel_feeder.sv
// rtl/voxel_feeder.sv - walks voxel memory issuing rasterize commands, then the palette issuing shade commands
module voxel_feeder
  import gpu::*;
#(
  parameter int COORD_BITS   = 8,
  parameter int PALETTE_BITS = 8,
  parameter int PIXEL_BITS   = 8,
  parameter int ADDR_BITS    = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDR_BITS:0]                  num_voxels,
  input  logic [PALETTE_BITS-1:0]             num_palette,
  output logic [ADDR_BITS-1:0]                voxel_addr,
  output logic                                voxel_rd,
  input  logic [PALETTE_BITS+3*COORD_BITS-1:0] voxel_word,
  output logic [PALETTE_BITS-1:0]             palette_addr,
  output logic                                palette_rd,
  input  logic [PIXEL_BITS-1:0]               palette_data,
  output logic                                do_rasterize,
  output logic                                do_shade,
  output logic [COORD_BITS-1:0]               voxel_x,
  output logic [COORD_BITS-1:0]               voxel_y,
  output logic [COORD_BITS-1:0]               voxel_z,
  output logic [PALETTE_BITS-1:0]             voxel_id,
  output logic [PIXEL_BITS-1:0]               palette_entry,
  input  logic                                rasterizing_done,
  input  logic                                shading_done,
  output logic                                busy,
  output logic                                frame_done
);

  localparam int XL  = field_lsb(X_FIELD, COORD_BITS);
  localparam int YL  = field_lsb(Y_FIELD, COORD_BITS);
  localparam int ZL  = field_lsb(Z_FIELD, COORD_BITS);
  localparam int IDL = field_lsb(ID_FIELD, COORD_BITS);

  localparam logic [ADDR_BITS:0]    VONE = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [PALETTE_BITS:0] PONE = {{PALETTE_BITS{1'b0}}, 1'b1};

  state_t state, next_state;

  logic [ADDR_BITS:0]      n_vox;
  logic [ADDR_BITS:0]      vcnt;
  logic [ADDR_BITS:0]      vcnt_next;
  logic [PALETTE_BITS-1:0] n_pal;
  logic [PALETTE_BITS:0]   pid;

  logic [COORD_BITS-1:0]   w_x, w_y, w_z;
  logic [PALETTE_BITS-1:0] w_id;
  logic                    w_empty;
  logic                    last_voxel;
  logic                    last_pal;

  assign w_x     = voxel_word[XL +: COORD_BITS];
  assign w_y     = voxel_word[YL +: COORD_BITS];
  assign w_z     = voxel_word[ZL +: COORD_BITS];
  assign w_id    = voxel_word[IDL +: PALETTE_BITS];
  assign w_empty = (w_id == '0);

  // Counters carry one extra bit so a full memory or full palette ends cleanly.
  assign vcnt_next  = vcnt + VONE;
  assign last_voxel = (vcnt_next == n_vox);
  assign last_pal   = (pid == {1'b0, n_pal});

  assign voxel_addr   = vcnt[ADDR_BITS-1:0];
  assign palette_addr = pid[PALETTE_BITS-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    voxel_rd     = 1'b0;
    palette_rd   = 1'b0;
    do_rasterize = 1'b0;
    do_shade     = 1'b0;
    frame_done   = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) next_state = (num_voxels == '0) ? S_FETCH : R_FETCH;
      end
      R_FETCH: begin
        voxel_rd   = 1'b1;
        next_state = R_LOAD;
      end
      R_LOAD: begin
        if (!w_empty)       next_state = R_ISSUE;
        else if (last_voxel) next_state = S_FETCH;
        else                 next_state = R_FETCH;
      end
      R_ISSUE: begin
        do_rasterize = 1'b1;
        if (rasterizing_done) next_state = last_voxel ? S_FETCH : R_FETCH;
      end
      S_FETCH: begin
        if (n_pal == '0) begin
          next_state = FINISH;
        end else begin
          palette_rd = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_LOAD: next_state = S_ISSUE;
      S_ISSUE: begin
        do_shade = 1'b1;
        if (shading_done) next_state = last_pal ? FINISH : S_FETCH;
      end
      FINISH: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Empty voxels leave the shader operands untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_vox         <= '0;
      n_pal         <= '0;
      vcnt          <= '0;
      pid           <= '0;
      voxel_x       <= '0;
      voxel_y       <= '0;
      voxel_z       <= '0;
      voxel_id      <= '0;
      palette_entry <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_vox <= num_voxels;
            n_pal <= num_palette;
            vcnt  <= '0;
            pid   <= PONE;
          end
        end
        R_LOAD: begin
          if (!w_empty) begin
            voxel_x  <= w_x;
            voxel_y  <= w_y;
            voxel_z  <= w_z;
            voxel_id <= w_id;
          end else begin
            vcnt <= vcnt_next;
          end
        end
        R_ISSUE: begin
          if (rasterizing_done) vcnt <= vcnt_next;
        end
        S_LOAD: begin
          palette_entry <= palette_data;
          voxel_id      <= pid[PALETTE_BITS-1:0];
        end
        S_ISSUE: begin
          if (shading_done && !last_pal) pid <= pid + PONE;
        end
        default: ;
      endcase
    end
  end

endmodule
